// File: rtl/dram_axi_reader.sv
// rtl/dram_axi_reader.sv - AXI4 read master turning single DRAM read requests into INCR bursts
`timescale 1ns/1ps
module dram_axi_reader #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH    = 16,
    parameter int AXI_ID          = 0
) (
    input  logic                       m_axi_aclk,
    input  logic                       m_axi_aresetn,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    input  logic                       dram_buffer_full,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_busy,
    output logic                       dram_read_error,
    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);
    localparam int BEAT_BYTES = DRAM_DATA_WIDTH / 8;
    localparam int SIZE_LOG2  = $clog2(BEAT_BYTES);
    localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK = DRAM_ADDR_WIDTH'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t                     state_q, state_d;
    logic [DRAM_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                 arlen_q, arlen_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       arvalid_q, arvalid_d;
    logic                       busy_q, busy_d;
    logic                       error_q, error_d;
    logic                       dvalid_q, dvalid_d;
    logic [DRAM_DATA_WIDTH-1:0] data_q, data_d;
    logic                       crosses_4k;
    logic                       beat_bad;

    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == ST_DATA) && !dram_buffer_full;

    assign dram_read_data       = data_q;
    assign dram_read_data_valid = dvalid_q;
    assign dram_read_busy       = busy_q;
    assign dram_read_error      = error_q;

    // Offset within the 4KB page of the aligned start plus burst length in bytes.
    assign crosses_4k = ((32'(dram_read_addr[11:0]) & ~32'(BEAT_BYTES - 1))
                         + ((32'(dram_read_len) + 32'd1) << SIZE_LOG2)) > 32'd4096;

    assign beat_bad = (m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID_WIDTH'(AXI_ID))
                      || (m_axi_rlast != (cnt_q == 8'd0));

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        cnt_d     = cnt_q;
        arvalid_d = arvalid_q;
        busy_d    = busy_q;
        error_d   = error_q;
        data_d    = data_q;
        dvalid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dram_read_en) begin
                    araddr_d  = dram_read_addr & ~BEAT_MASK;
                    arlen_d   = dram_read_len;
                    cnt_d     = dram_read_len;
                    error_d   = crosses_4k;
                    busy_d    = 1'b1;
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    data_d   = m_axi_rdata;
                    dvalid_d = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                    if (beat_bad) begin
                        error_d = 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= ST_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            dvalid_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            dvalid_q  <= dvalid_d;
            data_q    <= data_d;
        end
    end
endmodule
